// File: rtl/button_conditioner.sv
// ---------------------------------------------------------------------------
// button_conditioner
//
// Cleans up raw push-button pins for the stopwatch control logic. Every
// channel is synchronised, debounced by a stable-sample counter, and turned
// into a debounced level plus one-cycle press, release and long-press pulses.
//
// Parameters:
//   N_BTN            number of independent button channels
//   DEBOUNCE_CYCLES  consecutive cycles a new level must hold (>= 1)
//   LONG_CYCLES      cycles the level must stay high for a long press (>= 2)
//
// Ports:
//   clk          rising-edge clock
//   rst_n        asynchronous, active-low reset
//   btn_raw      raw, asynchronous, bouncing inputs (active high)
//   btn_level    debounced level per channel
//   btn_press    one-cycle pulse on each accepted 0->1 transition
//   btn_release  one-cycle pulse on each accepted 1->0 transition
//   btn_long     one-cycle pulse, once per press, after LONG_CYCLES high
// ---------------------------------------------------------------------------
module button_conditioner #(
    parameter int N_BTN           = 4,
    parameter int DEBOUNCE_CYCLES = 120000,
    parameter int LONG_CYCLES     = 12000000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_BTN-1:0] btn_raw,
    output logic [N_BTN-1:0] btn_level,
    output logic [N_BTN-1:0] btn_press,
    output logic [N_BTN-1:0] btn_release,
    output logic [N_BTN-1:0] btn_long
);

    localparam int CNT_W  = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int HOLD_W = $clog2(LONG_CYCLES);

    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_CYCLES - 1);

    // Two-flop synchroniser; only s2 is trusted downstream.
    logic [N_BTN-1:0] s1;
    logic [N_BTN-1:0] s2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1 <= '0;
            s2 <= '0;
        end else begin
            s1 <= btn_raw;
            s2 <= s1;
        end
    end

    for (genvar i = 0; i < N_BTN; i++) begin : g_ch
        logic [CNT_W-1:0]  cnt;
        logic [HOLD_W-1:0] hold;
        logic              level_q;
        logic              press_q;
        logic              rel_q;
        logic              long_q;
        logic              long_done;

        // Debounce: any sample matching the current level restarts the count,
        // so only an unbroken run of DEBOUNCE_CYCLES differing samples flips it.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                cnt     <= '0;
                level_q <= 1'b0;
                press_q <= 1'b0;
                rel_q   <= 1'b0;
            end else begin
                press_q <= 1'b0;
                rel_q   <= 1'b0;
                if (s2[i] == level_q) begin
                    cnt <= '0;
                end else if (cnt == CNT_LAST) begin
                    level_q <= s2[i];
                    cnt     <= '0;
                    press_q <= s2[i];
                    rel_q   <= ~s2[i];
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end
        end

        // Hold timer: the counter sees the level still low on the rising edge,
        // so it starts from zero there and a long pulse can never share a cycle
        // with the press pulse. long_done blocks repeats until the level falls.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                hold      <= '0;
                long_q    <= 1'b0;
                long_done <= 1'b0;
            end else begin
                long_q <= 1'b0;
                if (!level_q) begin
                    hold      <= '0;
                    long_done <= 1'b0;
                end else begin
                    if (hold != HOLD_LAST) begin
                        hold <= hold + 1'b1;
                    end
                    if ((hold == HOLD_LAST) && !long_done) begin
                        long_q    <= 1'b1;
                        long_done <= 1'b1;
                    end
                end
            end
        end

        assign btn_level[i]   = level_q;
        assign btn_press[i]   = press_q;
        assign btn_release[i] = rel_q;
        assign btn_long[i]    = long_q;
    end

endmodule
